// File: rtl/rr_mux_nx1.sv
// rr_mux_nx1: N-to-1 valid/ready multiplexer with an internal arbiter
// (round-robin or fixed priority) and a one-entry registered output stage.
// in_ready depends combinationally only on in_valid, out_ready and reset;
// out_data/out_sel/out_valid come straight from registers.
module rr_mux_nx1 #(
    parameter int data_width = 32,
    parameter int num_ch     = 4,
    parameter int arb_mode   = 0    // 0: round-robin, 1: fixed priority (ch 0 highest)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_ch-1:0]              in_valid,
    input  logic [num_ch*data_width-1:0]   in_data,
    output logic [num_ch-1:0]              in_ready,
    output logic                           out_valid,
    output logic [data_width-1:0]          out_data,
    output logic [$clog2(num_ch)-1:0]      out_sel,
    input  logic                           out_ready
);

    localparam int sel_w = $clog2(num_ch);

    typedef logic [sel_w-1:0] sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    sel_t              ptr;
    sel_t              gnt_idx;
    logic [num_ch-1:0] grant;
    logic              gnt_any;
    logic              load_ok;
    logic              xfer;

    assign out_valid = (state == FULL);
    assign load_ok   = !out_valid || out_ready;

    // Arbiter: scan in_valid from the start index (ptr in round-robin, 0 in
    // fixed priority), wrapping at num_ch so non-power-of-two counts never
    // produce an index at or above num_ch.
    always_comb begin
        int idx;
        // NOTE: every variable written here gets a default first, so no
        // path through the block leaves it unassigned and no latch is inferred.
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < num_ch; k++) begin
            if (arb_mode == 0) begin
                idx = int'(ptr) + k;
            end else begin
                idx = k;
            end
            if (idx >= num_ch) begin
                idx = idx - num_ch;
            end
            if (!gnt_any && in_valid[sel_t'(idx)]) begin
                grant[sel_t'(idx)] = 1'b1;
                gnt_idx            = sel_t'(idx);
                gnt_any            = 1'b1;
            end
        end
    end

    // A grant only becomes an accept when the output stage can take a beat;
    // nothing is accepted while reset is held.
    assign in_ready = (load_ok && !reset) ? grant : '0;
    assign xfer     = gnt_any && load_ok && !reset;

    // Next output-stage state: load wins over drain, drain without load empties.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (xfer) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (xfer) begin
                    state_nxt = FULL;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Output-stage state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat capture and round-robin pointer update on each transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the data path is reset as well, so out_data/out_sel read
            // zero after reset instead of a stale beat.
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            out_data <= in_data[int'(gnt_idx)*data_width +: data_width];
            out_sel  <= gnt_idx;
            if (arb_mode == 0) begin
                if (int'(gnt_idx) == num_ch - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= gnt_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_nx1.sv
// tb_rr_mux_nx1: table-driven and scoreboard checks for rr_mux_nx1 in
// round-robin (4 and 3 channels) and fixed-priority (4 channels) builds.
module tb_rr_mux_nx1;

    logic clk;
    logic reset;

    // 4-channel round-robin instance
    logic [3:0]   rr_iv;
    logic [127:0] rr_id;
    logic [3:0]   rr_ir;
    logic         rr_ov;
    logic [31:0]  rr_od;
    logic [1:0]   rr_os;
    logic         rr_or;

    // 4-channel fixed-priority instance
    logic [3:0]   fp_iv;
    logic [127:0] fp_id;
    logic [3:0]   fp_ir;
    logic         fp_ov;
    logic [31:0]  fp_od;
    logic [1:0]   fp_os;
    logic         fp_or;

    // 3-channel round-robin instance
    logic [2:0]   t3_iv;
    logic [95:0]  t3_id;
    logic [2:0]   t3_ir;
    logic         t3_ov;
    logic [31:0]  t3_od;
    logic [1:0]   t3_os;
    logic         t3_or;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] ready;
        logic       valid;
        logic [1:0] sel;
    } vec_t;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } beat_t;

    vec_t  vecs[13];
    beat_t sb_q[$];

    rr_mux_nx1 #(.data_width(32), .num_ch(4), .arb_mode(0)) dut_rr (
        .clk(clk), .reset(reset),
        .in_valid(rr_iv), .in_data(rr_id), .in_ready(rr_ir),
        .out_valid(rr_ov), .out_data(rr_od), .out_sel(rr_os), .out_ready(rr_or)
    );

    rr_mux_nx1 #(.data_width(32), .num_ch(4), .arb_mode(1)) dut_fp (
        .clk(clk), .reset(reset),
        .in_valid(fp_iv), .in_data(fp_id), .in_ready(fp_ir),
        .out_valid(fp_ov), .out_data(fp_od), .out_sel(fp_os), .out_ready(fp_or)
    );

    rr_mux_nx1 #(.data_width(32), .num_ch(3), .arb_mode(0)) dut_t3 (
        .clk(clk), .reset(reset),
        .in_valid(t3_iv), .in_data(t3_id), .in_ready(t3_ir),
        .out_valid(t3_ov), .out_data(t3_od), .out_sel(t3_os), .out_ready(t3_or)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  fp_seq_iv  [5];
        logic [3:0]  fp_seq_rdy [5];
        logic [1:0]  fp_seq_sel [5];
        logic [1:0]  t3_seq_sel [4];
        logic        hs;
        beat_t       b;

        // Round-robin vectors, starting from reset (ptr=0, empty).
        // Channel i carries 32'hA0+i, so expected out_data is 32'hA0+sel.
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};  // ptr -> 2
        vecs[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};  // ptr -> 3
        vecs[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};  // drain, sel held
        vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};  // idle, ptr held
        vecs[9]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};  // wrap 3 -> 0
        vecs[10] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};  // from ptr=1
        vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};  // hold under backpressure
        vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};

        fp_seq_iv[0] = 4'b1010; fp_seq_rdy[0] = 4'b0010; fp_seq_sel[0] = 2'd1;
        fp_seq_iv[1] = 4'b1010; fp_seq_rdy[1] = 4'b0010; fp_seq_sel[1] = 2'd1;
        fp_seq_iv[2] = 4'b1010; fp_seq_rdy[2] = 4'b0010; fp_seq_sel[2] = 2'd1;
        fp_seq_iv[3] = 4'b1000; fp_seq_rdy[3] = 4'b1000; fp_seq_sel[3] = 2'd3;
        fp_seq_iv[4] = 4'b1000; fp_seq_rdy[4] = 4'b1000; fp_seq_sel[4] = 2'd3;

        t3_seq_sel[0] = 2'd0;
        t3_seq_sel[1] = 2'd1;
        t3_seq_sel[2] = 2'd2;
        t3_seq_sel[3] = 2'd0;

        for (int i = 0; i < 4; i++) begin
            rr_id[i*32 +: 32] = 32'hA0 + 32'(i);
            fp_id[i*32 +: 32] = 32'hC0 + 32'(i);
        end
        for (int i = 0; i < 3; i++) begin
            t3_id[i*32 +: 32] = 32'hB0 + 32'(i);
        end

        // Reset state: requests present, but nothing is accepted while reset is high.
        reset = 1'b1;
        rr_iv = 4'b1111; rr_or = 1'b0;
        fp_iv = 4'b1111; fp_or = 1'b0;
        t3_iv = 3'b000;  t3_or = 1'b0;
        #1;
        check("reset_rr_in_ready", 64'(rr_ir), 64'h0);
        check("reset_fp_in_ready", 64'(fp_ir), 64'h0);
        check("reset_rr_out_valid", 64'(rr_ov), 64'h0);
        check("reset_rr_out_sel", 64'(rr_os), 64'h0);
        check("reset_rr_out_data", 64'(rr_od), 64'h0);
        check("reset_t3_out_valid", 64'(t3_ov), 64'h0);
        fp_iv = 4'b0000;
        @(negedge clk);
        reset = 1'b0;

        // Round-robin table.
        for (int i = 0; i < 13; i++) begin
            rr_iv = vecs[i].iv;
            rr_or = vecs[i].ordy;
            #1;
            check($sformatf("rr_vec%0d_in_ready", i), 64'(rr_ir), 64'(vecs[i].ready));
            @(posedge clk);
            #2;
            check($sformatf("rr_vec%0d_out_valid", i), 64'(rr_ov), 64'(vecs[i].valid));
            check($sformatf("rr_vec%0d_out_sel", i), 64'(rr_os), 64'(vecs[i].sel));
            check($sformatf("rr_vec%0d_out_data", i), 64'(rr_od), 64'h0A0 + 64'(vecs[i].sel));
        end

        // Backpressure: load channel 2 (ptr=3 here), then stall 5 cycles with ch0 waiting.
        rr_id[2*32 +: 32] = 32'hDEADBEEF;
        rr_iv = 4'b0100;
        rr_or = 1'b0;
        #1;
        check("bp_load_in_ready", 64'(rr_ir), 64'b0100);
        @(posedge clk);
        #2;
        check("bp_load_out_data", 64'(rr_od), 64'hDEADBEEF);
        check("bp_load_out_sel", 64'(rr_os), 64'd2);
        rr_id[2*32 +: 32] = 32'hA2;
        rr_iv = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_stall%0d_in_ready", c), 64'(rr_ir), 64'h0);
            @(posedge clk);
            #2;
            check($sformatf("bp_stall%0d_out_valid", c), 64'(rr_ov), 64'h1);
            check($sformatf("bp_stall%0d_out_data", c), 64'(rr_od), 64'hDEADBEEF);
            check($sformatf("bp_stall%0d_out_sel", c), 64'(rr_os), 64'd2);
        end
        rr_or = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(rr_ir), 64'b0001);
        @(posedge clk);
        #2;
        check("bp_release_out_valid", 64'(rr_ov), 64'h1);
        check("bp_release_out_sel", 64'(rr_os), 64'd0);
        check("bp_release_out_data", 64'(rr_od), 64'hA0);
        // Park the round-robin instance FULL (ptr=1) for the mid-run reset test.
        rr_iv = 4'b0000;
        rr_or = 1'b0;

        // Fixed priority, scoreboard-checked.
        for (int i = 0; i < 5; i++) begin
            fp_iv = fp_seq_iv[i];
            fp_or = 1'b1;
            #1;
            check($sformatf("fp_step%0d_in_ready", i), 64'(fp_ir), 64'(fp_seq_rdy[i]));
            b.sel  = fp_seq_sel[i];
            b.data = 32'hC0 + 32'(fp_seq_sel[i]);
            sb_q.push_back(b);
            hs = |(fp_iv & fp_ir);
            @(posedge clk);
            #2;
            if (hs && sb_q.size() > 0) begin
                b = sb_q.pop_front();
                check($sformatf("fp_beat%0d_out_valid", i), 64'(fp_ov), 64'h1);
                check($sformatf("fp_beat%0d_out_sel", i), 64'(fp_os), 64'(b.sel));
                check($sformatf("fp_beat%0d_out_data", i), 64'(fp_od), 64'(b.data));
            end
        end
        check("fp_scoreboard_empty", 64'(sb_q.size()), 64'h0);
        fp_iv = 4'b0000;
        #1;
        check("fp_idle_in_ready", 64'(fp_ir), 64'h0);
        @(posedge clk);
        #2;
        check("fp_idle_out_valid", 64'(fp_ov), 64'h0);
        check("fp_idle_out_sel", 64'(fp_os), 64'd3);

        // Three channels, all valid: 0,1,2,0 with wrap from 2 to 0.
        for (int i = 0; i < 4; i++) begin
            t3_iv = 3'b111;
            t3_or = 1'b1;
            #1;
            b.sel  = t3_seq_sel[i];
            b.data = 32'hB0 + 32'(t3_seq_sel[i]);
            sb_q.push_back(b);
            hs = |(t3_iv & t3_ir);
            @(posedge clk);
            #2;
            if (hs && sb_q.size() > 0) begin
                b = sb_q.pop_front();
                check($sformatf("t3_beat%0d_out_sel", i), 64'(t3_os), 64'(b.sel));
                check($sformatf("t3_beat%0d_out_data", i), 64'(t3_od), 64'(b.data));
            end
        end
        check("t3_scoreboard_empty", 64'(sb_q.size()), 64'h0);
        t3_iv = 3'b000;

        // Mid-cycle reset with a held beat: out_valid must drop without a clock edge.
        check("midrst_pre_out_valid", 64'(rr_ov), 64'h1);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(rr_ov), 64'h0);
        check("midrst_out_sel", 64'(rr_os), 64'h0);
        check("midrst_out_data", 64'(rr_od), 64'h0);
        rr_iv = 4'b1111;
        rr_or = 1'b1;
        #1;
        check("midrst_in_ready_held", 64'(rr_ir), 64'h0);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_first_grant", 64'(rr_ir), 64'b0001);
        @(posedge clk);
        #2;
        check("midrst_first_out_sel", 64'(rr_os), 64'd0);
        check("midrst_first_out_data", 64'(rr_od), 64'hA0);
        #1;
        check("midrst_second_grant", 64'(rr_ir), 64'b0010);
        rr_iv = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
